alu_exec: RTL

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec_if.sv | 25 ++
 rtl/alu_exec.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_exec_if.sv
// Request/response bundle for the alu_exec operation stage.
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_select;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_select, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_select, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// RV32I execute-stage ALU with valid/ready handshakes; shifts run one bit per
// cycle through a working register, everything else completes on acceptance.
module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SRL  = 4'd3,
    OP_SRA  = 4'd4,
    OP_XOR  = 4'd5,
    OP_OR   = 4'd6,
    OP_AND  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } op_t;

  state_t          state, state_n;
  logic            alive;
  logic [3:0]      sel_q;
  logic [XLEN-1:0] work;
  logic [4:0]      cnt;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            illegal_q;

  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] shifted;
  logic [4:0]      shamt;
  logic            is_shift;
  logic            legal;
  logic            accept;

  assign shamt         = bus.op_b[4:0];
  // Ready is held low until the first edge after reset release.
  assign bus.in_ready  = alive && (state == IDLE);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

  always_comb begin
    alu_res  = '0;
    is_shift = 1'b0;
    legal    = 1'b1;
    case (bus.alu_select)
      OP_ADD:  alu_res = bus.op_a + bus.op_b;
      OP_SUB:  alu_res = bus.op_a - bus.op_b;
      OP_SLL, OP_SRL, OP_SRA: begin
        is_shift = 1'b1;
        alu_res  = bus.op_a;
      end
      OP_XOR:  alu_res = bus.op_a ^ bus.op_b;
      OP_OR:   alu_res = bus.op_a | bus.op_b;
      OP_AND:  alu_res = bus.op_a & bus.op_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    shifted = work;
    case (sel_q)
      OP_SLL:  shifted = {work[XLEN-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, work[XLEN-1:1]};
      OP_SRA:  shifted = {work[XLEN-1], work[XLEN-1:1]};
      default: shifted = work;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = (is_shift && shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt == 5'd1) state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_n;
      alive <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      work      <= '0;
      cnt       <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sel_q <= bus.alu_select;
          if (is_shift && shamt != '0) begin
            work <= bus.op_a;
            cnt  <= shamt;
          end else begin
            result_q  <= alu_res;
            zero_q    <= (alu_res == '0);
            illegal_q <= ~legal;
          end
        end
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - 5'd1;
          // The final step publishes the shifted value as it enters DONE.
          if (cnt == 5'd1) begin
            result_q  <= shifted;
            zero_q    <= (shifted == '0);
            illegal_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
